// File: rtl/vga_scaler.sv
// VGA timing generator with integer upscaling of a smaller framebuffer.
// Framebuffer reads are pipelined; sync and colour pins are delay-matched to the returned pixels.
module vga_scaler #(
    parameter int CLK_DIV       = 2,
    parameter int H_VISIBLE     = 640,
    parameter int H_FP          = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BP          = 48,
    parameter int V_VISIBLE     = 480,
    parameter int V_FP          = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 33,
    parameter int SCALE         = 3,
    parameter int FB_WIDTH      = (H_VISIBLE + SCALE - 1) / SCALE,
    parameter int COLOR_BITS    = 1,
    parameter int FB_LATENCY    = 1,
    parameter int FB_ADDR_WIDTH = 16,
    parameter bit HSYNC_POL     = 1'b0,
    parameter bit VSYNC_POL     = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_async_n,
    input  logic                      en,
    output logic [FB_ADDR_WIDTH-1:0]  fb_addr,
    output logic                      fb_rd_en,
    input  logic [3*COLOR_BITS-1:0]   fb_pixel,
    output logic [COLOR_BITS-1:0]     vga_r,
    output logic [COLOR_BITS-1:0]     vga_g,
    output logic [COLOR_BITS-1:0]     vga_b,
    output logic                      vga_hsync,
    output logic                      vga_vsync,
    output logic                      frame_start,
    output logic                      vblank
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int X_W     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int Y_W     = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int REP_W   = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int COL_W   = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;

    if (CLK_DIV < 1) begin : g_chk_div
        $error("vga_scaler: CLK_DIV must be at least 1");
    end
    if (SCALE < 1) begin : g_chk_scale
        $error("vga_scaler: SCALE must be at least 1");
    end
    if (FB_LATENCY < 1) begin : g_chk_lat
        $error("vga_scaler: FB_LATENCY must be at least 1");
    end
    if (H_SYNC < 1 || V_SYNC < 1 || H_VISIBLE < 1 || V_VISIBLE < 1) begin : g_chk_timing
        $error("vga_scaler: visible and sync widths must be at least 1");
    end
    if (FB_WIDTH * SCALE < H_VISIBLE) begin : g_chk_width
        $error("vga_scaler: FB_WIDTH * SCALE must cover H_VISIBLE");
    end

    typedef struct packed {
        logic vis;
        logic hs;
        logic vs;
        logic fs;
        logic vb;
    } flags_t;

    // Timing and scaling state; run is low while idle so a fresh frame starts at x=0, y=0.
    logic                     run, run_n;
    logic [DIV_W-1:0]         div_cnt, div_n;
    logic [X_W-1:0]           x_cnt, x_n;
    logic [Y_W-1:0]           y_cnt, y_n;
    logic [REP_W-1:0]         x_rep, x_rep_n;
    logic [REP_W-1:0]         y_rep, y_rep_n;
    logic [COL_W-1:0]         fb_col, fb_col_n;
    logic [FB_ADDR_WIDTH-1:0] line_base, line_base_n;

    logic   pix_tick;
    logic   h_vis, v_vis, vis_now, vis_n;
    flags_t cur_flags;
    flags_t dly [FB_LATENCY];
    flags_t dly_out;

    assign pix_tick = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign h_vis    = (x_cnt < X_W'(H_VISIBLE));
    assign v_vis    = (y_cnt < Y_W'(V_VISIBLE));
    assign vis_now  = run && h_vis && v_vis;
    assign vis_n    = run_n && (x_n < X_W'(H_VISIBLE)) && (y_n < Y_W'(V_VISIBLE));

    always_comb begin
        // NOTE: every next-state variable is given its hold value first, so no path leaves one unassigned and no latch is inferred.
        run_n       = run;
        div_n       = div_cnt;
        x_n         = x_cnt;
        y_n         = y_cnt;
        x_rep_n     = x_rep;
        y_rep_n     = y_rep;
        fb_col_n    = fb_col;
        line_base_n = line_base;

        if (!en || !run) begin
            run_n       = en;
            div_n       = '0;
            x_n         = '0;
            y_n         = '0;
            x_rep_n     = '0;
            y_rep_n     = '0;
            fb_col_n    = '0;
            line_base_n = '0;
        end else begin
            div_n = pix_tick ? '0 : div_cnt + 1'b1;
            if (pix_tick) begin
                if (vis_now) begin
                    if (x_cnt == X_W'(H_VISIBLE - 1)) begin
                        x_rep_n  = '0;
                        fb_col_n = '0;
                        if (y_cnt == Y_W'(V_VISIBLE - 1)) begin
                            y_rep_n     = '0;
                            line_base_n = '0;
                        end else if (y_rep == REP_W'(SCALE - 1)) begin
                            y_rep_n     = '0;
                            line_base_n = line_base + FB_ADDR_WIDTH'(FB_WIDTH);
                        end else begin
                            y_rep_n = y_rep + 1'b1;
                        end
                    end else if (x_rep == REP_W'(SCALE - 1)) begin
                        x_rep_n  = '0;
                        fb_col_n = fb_col + 1'b1;
                    end else begin
                        x_rep_n = x_rep + 1'b1;
                    end
                end

                if (x_cnt == X_W'(H_TOTAL - 1)) begin
                    x_n = '0;
                    y_n = (y_cnt == Y_W'(V_TOTAL - 1)) ? '0 : y_cnt + 1'b1;
                end else begin
                    x_n = x_cnt + 1'b1;
                end
            end
        end
    end

    // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            run       <= 1'b0;
            div_cnt   <= '0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            x_rep     <= '0;
            y_rep     <= '0;
            fb_col    <= '0;
            line_base <= '0;
        end else begin
            run       <= run_n;
            div_cnt   <= div_n;
            x_cnt     <= x_n;
            y_cnt     <= y_n;
            x_rep     <= x_rep_n;
            y_rep     <= y_rep_n;
            fb_col    <= fb_col_n;
            line_base <= line_base_n;
        end
    end

    // The address is built from next-state values so fb_addr lines up with the counters it belongs to.
    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            fb_addr  <= '0;
            fb_rd_en <= 1'b0;
        end else begin
            fb_rd_en <= vis_n;
            if (vis_n) begin
                fb_addr <= line_base_n + FB_ADDR_WIDTH'(fb_col_n);
            end
        end
    end

    always_comb begin
        cur_flags     = '0;
        cur_flags.vis = vis_now;
        cur_flags.hs  = run && (x_cnt >= X_W'(H_VISIBLE + H_FP))
                            && (x_cnt <= X_W'(H_VISIBLE + H_FP + H_SYNC - 1));
        cur_flags.vs  = run && (y_cnt >= Y_W'(V_VISIBLE + V_FP))
                            && (y_cnt <= Y_W'(V_VISIBLE + V_FP + V_SYNC - 1));
        cur_flags.fs  = run && (div_cnt == '0) && (x_cnt == '0) && (y_cnt == '0);
        cur_flags.vb  = run && !v_vis;
    end

    // NOTE: the delay line is a handful of flag registers, so it is reset like ordinary state rather than treated as memory.
    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            for (int i = 0; i < FB_LATENCY; i++) dly[i] <= '0;
        end else if (!en) begin
            for (int i = 0; i < FB_LATENCY; i++) dly[i] <= '0;
        end else begin
            dly[0] <= cur_flags;
            for (int i = 1; i < FB_LATENCY; i++) dly[i] <= dly[i-1];
        end
    end

    assign dly_out = dly[FB_LATENCY-1];

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hsync   <= ~HSYNC_POL;
            vga_vsync   <= ~VSYNC_POL;
            frame_start <= 1'b0;
            vblank      <= 1'b0;
        end else if (!en) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hsync   <= ~HSYNC_POL;
            vga_vsync   <= ~VSYNC_POL;
            frame_start <= 1'b0;
            vblank      <= 1'b0;
        end else begin
            vga_r       <= dly_out.vis ? fb_pixel[3*COLOR_BITS-1:2*COLOR_BITS] : '0;
            vga_g       <= dly_out.vis ? fb_pixel[2*COLOR_BITS-1:COLOR_BITS]   : '0;
            vga_b       <= dly_out.vis ? fb_pixel[COLOR_BITS-1:0]              : '0;
            vga_hsync   <= dly_out.hs ? HSYNC_POL : ~HSYNC_POL;
            vga_vsync   <= dly_out.vs ? VSYNC_POL : ~VSYNC_POL;
            frame_start <= dly_out.fs;
            vblank      <= dly_out.vb;
        end
    end

endmodule
